// File: rtl/zap_ram_arbiter.sv
// zap_ram_arbiter
// Shares the single external RAM port between the I-fill, D-fill and
// write-buffer drain clients. Arbitration is round-robin, and the winner keeps
// the port for a burst. A burst ends when the owner drops its request. It is
// also cut short after MAX_BURST beats, but only if another client is waiting.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner; arbitrate among requesters for one cycle
// OWN   | owner drives the RAM port; beats complete when i_ram_wait=0
module zap_ram_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_BURST   = 8
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [NUM_MASTERS-1:0]        i_req,
  input  logic [NUM_MASTERS-1:0]        i_wen,
  input  logic [NUM_MASTERS*ADDR_W-1:0] i_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] i_wdata,
  output logic [NUM_MASTERS-1:0]        o_gnt,
  output logic [NUM_MASTERS-1:0]        o_ack,
  output logic [DATA_W-1:0]             o_rdata,
  output logic                          o_ram_req,
  output logic                          o_ram_wen,
  output logic [ADDR_W-1:0]             o_ram_addr,
  output logic [DATA_W-1:0]             o_ram_data,
  input  logic [DATA_W-1:0]             i_ram_data,
  input  logic                          i_ram_wait
);

  localparam int OW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t                 state;
  logic [OW-1:0]          owner;
  logic [OW-1:0]          rr_ptr;
  logic [CW-1:0]          beat_cnt;
  logic [NUM_MASTERS-1:0] gnt_q;

  logic [OW-1:0]          pick;
  logic                   pick_vld;
  int                     idx;
  logic [NUM_MASTERS-1:0] owner_oh;
  logic                   beat_done;
  logic                   others_req;
  logic                   burst_full;
  logic [OW-1:0]          nxt_ptr;

  // Cyclic search for the first requester at or after rr_ptr.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_MASTERS;
      if (!pick_vld && i_req[idx]) begin
        pick     = OW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  assign owner_oh   = NUM_MASTERS'(1) << owner;
  assign beat_done  = (state == OWN) && i_req[owner] && !i_ram_wait;
  assign others_req = |(i_req & ~owner_oh);
  assign burst_full = (32'(beat_cnt) + 32'd1) >= 32'(MAX_BURST);
  assign nxt_ptr    = (owner == OW'(NUM_MASTERS - 1)) ? '0 : owner + 1'b1;

  // Owner's request and payload steered to the RAM port; zero when idle.
  always_comb begin
    o_ram_req  = 1'b0;
    o_ram_wen  = 1'b0;
    o_ram_addr = '0;
    o_ram_data = '0;
    o_ack      = '0;
    if (state == OWN) begin
      o_ram_req  = i_req[owner];
      o_ram_wen  = i_wen[owner];
      o_ram_addr = i_addr[owner*ADDR_W +: ADDR_W];
      o_ram_data = i_wdata[owner*DATA_W +: DATA_W];
      if (beat_done) o_ack[owner] = 1'b1;
    end
  end

  assign o_rdata = i_ram_data;
  assign o_gnt   = gnt_q;

  // Ownership FSM: grant, burst counting, voluntary and forced release.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      gnt_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            owner <= pick;
            gnt_q <= NUM_MASTERS'(1) << pick;
            state <= OWN;
          end
        end
        OWN: begin
          if (!i_req[owner] || (beat_done && burst_full && others_req)) begin
            state    <= IDLE;
            rr_ptr   <= nxt_ptr;
            beat_cnt <= '0;
            gnt_q    <= '0;
          end else if (beat_done && beat_cnt != CW'(MAX_BURST)) begin
            // A sole requester keeps the port; the count just stops at MAX_BURST.
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
